sysarr_mm: RTL and testbench

- Parametrised N×N output-stationary systolic matrix-multiply engine; next generation of the fixed 4×4 32-bit array.
- Computes C = A·B, where A is N×K and B is K×N, with K set at run time.
- Adds what the fixed array lacks:
  - internal input skewing
  - ready/valid streaming with stall
  - accumulator clear per job
  - drain sequencing
  - row-by-row result readout with back-pressure.
- Sits between the operand stream source and the result writeback path.

---
 rtl/sysarr_mm.sv | 206 ++++++++++++++++++++
 tb/tb_sysarr_mm.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_mm.sv
// N x N output-stationary systolic matrix multiplier: streams A columns / B rows,
// skews them internally, accumulates C = A*B in place and reads C out row by row.
module sysarr_mm #(
   parameter int unsigned N      = 4,
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned KW     = 8,
   parameter int unsigned SIGNED = 1,
   localparam int unsigned RW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*DW-1:0]   in_a,
   input  logic [N*DW-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*AW-1:0]   out_row,
   output logic [RW-1:0]     out_idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PW  = (AW > 2*DW) ? AW : 2*DW;
   localparam int unsigned DCW = $clog2(2*N);
   localparam logic        SGN = (SIGNED != 0);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

   state_t          state;
   logic [KW-1:0]   k_reg;
   logic [KW-1:0]   bcnt;
   logic [DCW-1:0]  dcnt;
   logic            clr;
   logic            en;

   logic [DW-1:0]   a_src [N];
   logic [DW-1:0]   b_src [N];
   logic [DW-1:0]   a_sk  [N];
   logic [DW-1:0]   b_sk  [N];
   logic [DW-1:0]   a_sr  [N][N];
   logic [DW-1:0]   b_sr  [N][N];
   logic [DW-1:0]   a_w   [N][N];
   logic [DW-1:0]   b_w   [N][N];
   logic [DW-1:0]   a_q   [N][N];
   logic [DW-1:0]   b_q   [N][N];
   logic [AW-1:0]   acc   [N][N];

   // Extending both operands to PW bits makes the low PW bits of the product exact.
   function automatic logic [PW-1:0] ext(input logic [DW-1:0] v);
      return {{(PW-DW){SGN & v[DW-1]}}, v};
   endfunction

   assign clr = (state == IDLE) && start;
   assign en  = ((state == LOAD) && in_valid && in_ready) || (state == DRAIN);

   // Only LOAD feeds real operands; DRAIN pushes zeros through the skew.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_src[i] = (state == LOAD) ? in_a[i*DW +: DW] : '0;
         b_src[i] = (state == LOAD) ? in_b[i*DW +: DW] : '0;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      if (gi == 0) begin : g_sk0
         assign a_sk[gi] = a_src[gi];
         assign b_sk[gi] = b_src[gi];
      end else begin : g_skn
         assign a_sk[gi] = a_sr[gi][gi-1];
         assign b_sk[gi] = b_sr[gi][gi-1];
      end
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         if (gj == 0) begin : g_a0
            assign a_w[gi][gj] = a_sk[gi];
         end else begin : g_an
            assign a_w[gi][gj] = a_q[gi][gj-1];
         end
         if (gi == 0) begin : g_b0
            assign b_w[gi][gj] = b_sk[gj];
         end else begin : g_bn
            assign b_w[gi][gj] = b_q[gi-1][gj];
         end
      end
   end

   // Array datapath: skew lines, operand pipeline and accumulators step together on en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_sr[i][j] <= '0;
               b_sr[i][j] <= '0;
               a_q[i][j]  <= '0;
               b_q[i][j]  <= '0;
               acc[i][j]  <= '0;
            end
         end
      end else if (clr) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_sr[i][j] <= '0;
               b_sr[i][j] <= '0;
               a_q[i][j]  <= '0;
               b_q[i][j]  <= '0;
               acc[i][j]  <= '0;
            end
         end
      end else if (en) begin
         for (int i = 0; i < N; i++) begin
            a_sr[i][0] <= a_src[i];
            b_sr[i][0] <= b_src[i];
            for (int d = 1; d < N; d++) begin
               a_sr[i][d] <= a_sr[i][d-1];
               b_sr[i][d] <= b_sr[i][d-1];
            end
            for (int j = 0; j < N; j++) begin
               a_q[i][j] <= a_w[i][j];
               b_q[i][j] <= b_w[i][j];
               acc[i][j] <= acc[i][j] + AW'(ext(a_w[i][j]) * ext(b_w[i][j]));
            end
         end
      end
   end

   // Job sequencing and handshake flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k_reg     <= '0;
         bcnt      <= '0;
         dcnt      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  k_reg   <= k_len;
                  bcnt    <= '0;
                  dcnt    <= '0;
                  out_idx <= '0;
                  busy    <= 1'b1;
                  if (k_len != '0) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end else begin
                     state     <= OUT;
                     out_valid <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid && in_ready) begin
                  bcnt <= bcnt + KW'(1);
                  if (bcnt == k_reg - KW'(1)) begin
                     in_ready <= 1'b0;
                     if (N > 1) begin
                        state <= DRAIN;
                     end else begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               dcnt <= dcnt + DCW'(1);
               if (dcnt == DCW'(2*N-3)) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (out_idx == RW'(N-1)) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_idx <= out_idx + RW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result row is a mux of the held accumulators, so it is stable under back-pressure.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         out_row[j*AW +: AW] = acc[out_idx][j];
      end
   end

endmodule

// File: tb/tb_sysarr_mm.sv
// Bench for sysarr_mm: a signed 64-bit-accumulator instance and an unsigned 32-bit one
// share stimulus; results are checked against a plain matrix-product model.
module tb_sysarr_mm;

   localparam int N    = 4;
   localparam int KMAX = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [7:0]    k_len;
   logic          in_valid;
   logic [127:0]  in_a;
   logic [127:0]  in_b;
   logic          out_ready;

   logic          in_ready_s, out_valid_s, busy_s, done_s;
   logic [255:0]  out_row_s;
   logic [1:0]    out_idx_s;
   logic          in_ready_u, out_valid_u, busy_u, done_u;
   logic [127:0]  out_row_u;
   logic [1:0]    out_idx_u;

   sysarr_mm #(.N(4), .DW(32), .AW(64), .KW(8), .SIGNED(1)) u_s (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s),
      .out_idx(out_idx_s), .busy(busy_s), .done(done_s));

   sysarr_mm #(.N(4), .DW(32), .AW(32), .KW(8), .SIGNED(0)) u_u (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready_u), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_row(out_row_u),
      .out_idx(out_idx_u), .busy(busy_u), .done(done_u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]   ma [N][KMAX];
   logic [31:0]   mb [KMAX][N];
   logic [255:0]  exp_s [N];
   logic [255:0]  got_s [N];
   logic [127:0]  exp_u [N];
   logic [127:0]  got_u [N];
   logic [1:0]    gidx  [N];

   int            lat;
   int            stab_err;
   int            ctl_diff;
   bit            tmo, ir_any, done_early, done_at, busy_end, ov_end, done_after, busy_start;
   logic [9:0]    ctl;
   int            n_cmp = 0;
   int            n_fail = 0;

   function automatic logic [63:0] model_s(int i, int j, int k);
      longint acc = 0;
      for (int kk = 0; kk < k; kk++)
         acc += longint'($signed(ma[i][kk])) * longint'($signed(mb[kk][j]));
      return acc;
   endfunction

   function automatic logic [31:0] model_u(int i, int j, int k);
      logic [63:0] acc = 0;
      for (int kk = 0; kk < k; kk++)
         acc += 64'(ma[i][kk]) * 64'(mb[kk][j]);
      return acc[31:0];
   endfunction

   task automatic fill_rand(input int k);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < k; kk++) begin
            ma[i][kk] = $urandom;
            mb[kk][i] = $urandom;
         end
   endtask

   task automatic drive_beat(input int idx);
      for (int i = 0; i < N; i++) begin
         in_a[i*32 +: 32] = ma[i][idx];
         in_b[i*32 +: 32] = mb[idx][i];
      end
   endtask

   // Drives one job and records rows, latency and control observations.
   task automatic run_job(input int k, input int gaps, input bit rtog, input bit poke,
                          input bit pre, input bit chain, input int chain_k);
      int idx, cyc, tog, rows, firstv;
      bit first, v, rdy, have_prev, poked;
      logic [385:0] prev;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            exp_s[i][j*64 +: 64] = model_s(i, j, k);
            exp_u[i][j*32 +: 32] = model_u(i, j, k);
         end
      tmo = 0; ir_any = 0; done_early = 0; done_at = 0; busy_end = 1; ov_end = 1;
      done_after = 0; busy_start = 0; stab_err = 0; ctl_diff = 0;
      prev = '0;
      if (!pre) begin
         @(negedge clk);
         start = 1'b1;
         k_len = 8'(k);
      end
      first = 1; idx = 0; cyc = 0;
      while (idx < k && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (first) begin busy_start = busy_s; first = 0; end
         v = (gaps == 0) ? 1'b1 : (gaps == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
         in_valid = v;
         if (v) drive_beat(idx);
         else begin
            in_a = {$urandom, $urandom, $urandom, $urandom};
            in_b = {$urandom, $urandom, $urandom, $urandom};
         end
         if (poke && idx == 1) begin start = 1'b1; k_len = 8'(k + 3); end
         if (v && in_ready_s) idx++;
      end
      if (idx < k) tmo = 1;
      lat = 0; tog = 0; rows = 0; firstv = -1; have_prev = 0; poked = 0;
      while (rows < N && lat < 300) begin
         @(negedge clk);
         lat++;
         in_valid = 1'b0;
         start = 1'b0;
         if (first) begin busy_start = busy_s; first = 0; end
         ir_any |= in_ready_s;
         done_early |= done_s;
         if ({in_ready_s, out_valid_s, out_idx_s, busy_s, done_s} !==
             {in_ready_u, out_valid_u, out_idx_u, busy_u, done_u}) ctl_diff++;
         rdy = rtog ? (tog % 2 == 0) : 1'b1;
         tog++;
         out_ready = rdy;
         if (out_valid_s) begin
            if (firstv < 0) firstv = lat;
            if (have_prev && ({out_row_s, out_row_u, out_idx_s} !== prev)) stab_err++;
            have_prev = 0;
            if (poke && !poked) begin start = 1'b1; k_len = 8'(k + 5); poked = 1; end
            if (rdy) begin
               got_s[rows] = out_row_s;
               got_u[rows] = out_row_u;
               gidx[rows]  = out_idx_s;
               rows++;
            end else begin
               prev = {out_row_s, out_row_u, out_idx_s};
               have_prev = 1;
            end
         end
      end
      if (rows < N) tmo = 1;
      lat = firstv;
      @(negedge clk);
      start = chain;
      k_len = 8'(chain_k);
      done_at = done_s; busy_end = busy_s; ov_end = out_valid_s;
      if (!chain) begin
         @(negedge clk);
         start = 1'b0;
         done_after = done_s;
      end
      ctl = {tmo, ir_any, done_early, ov_end, busy_end, done_at, busy_start,
             (ctl_diff != 0), (stab_err != 0), done_after};
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({in_ready_s, out_valid_s, done_s, busy_s, out_idx_s, out_row_s} !== '0) begin
         n_fail++;
         $display("FAIL reset_s: got rdy=%b ov=%b done=%b busy=%b idx=%0d row=%h, expected all 0",
                  in_ready_s, out_valid_s, done_s, busy_s, out_idx_s, out_row_s);
      end
      n_cmp++;
      if ({in_ready_u, out_valid_u, done_u, busy_u, out_idx_u, out_row_u} !== '0) begin
         n_fail++;
         $display("FAIL reset_u: got rdy=%b ov=%b done=%b busy=%b idx=%0d, expected all 0",
                  in_ready_u, out_valid_u, done_u, busy_u, out_idx_u);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({in_ready_s, out_valid_s, done_s, busy_s} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got rdy/ov/done/busy=%b, expected 0000",
                  {in_ready_s, out_valid_s, done_s, busy_s});
      end
   endtask

   task automatic test_identity(input int gaps, input bit rtog, input string nm);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 4; kk++) begin
            ma[i][kk] = (i == kk) ? 32'd1 : 32'd0;
            mb[kk][i] = 32'(10 * kk + i);
         end
      run_job(4, gaps, rtog, 0, 0, 0, 0);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r] || gidx[r] !== 2'(r)) begin
            n_fail++;
            $display("FAIL %s row%0d: got s=%h u=%h idx=%0d, expected s=%h u=%h idx=%0d",
                     nm, r, got_s[r], got_u[r], gidx[r], exp_s[r], exp_u[r], r);
         end
      end
      n_cmp++;
      if (got_u[2] !== {32'd23, 32'd22, 32'd21, 32'd20}) begin
         n_fail++;
         $display("FAIL %s row2_literal: got %h, expected 23,22,21,20", nm, got_u[2]);
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL %s control: got %b, expected 0000011000", nm, ctl);
      end
      if (gaps == 0 && !rtog) begin
         n_cmp++;
         if (lat !== 7) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected 7", nm, lat);
         end
      end
   endtask

   task automatic test_zero_k;
      run_job(0, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== '0 || got_u[r] !== '0 || gidx[r] !== 2'(r)) begin
            n_fail++;
            $display("FAIL zero_k row%0d: got s=%h u=%h idx=%0d, expected zeros idx=%0d",
                     r, got_s[r], got_u[r], gidx[r], r);
         end
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL zero_k control: got %b, expected 0000011000", ctl);
      end
   endtask

   task automatic test_signed_wrap;
      fill_rand(2);
      ma[0][0] = 32'hFFFF_FFFF; ma[0][1] = 32'hFFFF_FFFF;
      mb[0][0] = 32'd3;         mb[1][0] = 32'd3;
      run_job(2, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (got_s[0][63:0] !== 64'hFFFF_FFFF_FFFF_FFFA || got_u[0][31:0] !== 32'hFFFF_FFFA) begin
         n_fail++;
         $display("FAIL signed_c00: got s=%h u=%h, expected s=fffffffffffffffa u=fffffffa",
                  got_s[0][63:0], got_u[0][31:0]);
      end
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r]) begin
            n_fail++;
            $display("FAIL signed row%0d: got s=%h u=%h, expected s=%h u=%h",
                     r, got_s[r], got_u[r], exp_s[r], exp_u[r]);
         end
      end
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 2; kk++) begin
            ma[i][kk] = 32'h8000_0000;
            mb[kk][i] = 32'h8000_0000;
         end
      run_job(2, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (got_u[0][31:0] !== 32'h0 || got_s[0][63:0] !== 64'h8000_0000_0000_0000) begin
         n_fail++;
         $display("FAIL wrap_c00: got u=%h s=%h, expected u=00000000 s=8000000000000000",
                  got_u[0][31:0], got_s[0][63:0]);
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL wrap control: got %b, expected 0000011000", ctl);
      end
   endtask

   task automatic test_reset_mid_load;
      fill_rand(4);
      @(negedge clk); start = 1'b1; k_len = 8'd4;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; drive_beat(0);
      @(negedge clk); drive_beat(1);
      @(negedge clk); in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready_s, out_valid_s, done_s, busy_s, out_idx_s,
           in_ready_u, out_valid_u, done_u, busy_u, out_idx_u} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got s=%b u=%b, expected all 0",
                  {in_ready_s, out_valid_s, done_s, busy_s, out_idx_s},
                  {in_ready_u, out_valid_u, done_u, busy_u, out_idx_u});
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy_s !== 1'b0 || in_ready_s !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b rdy=%b, expected 0 0", busy_s, in_ready_s);
      end
      fill_rand(4);
      run_job(4, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r]) begin
            n_fail++;
            $display("FAIL after_reset row%0d: got s=%h u=%h, expected s=%h u=%h",
                     r, got_s[r], got_u[r], exp_s[r], exp_u[r]);
         end
      end
   endtask

   task automatic test_start_ignored;
      fill_rand(5);
      run_job(5, 1, 1, 1, 0, 0, 0);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r] || gidx[r] !== 2'(r)) begin
            n_fail++;
            $display("FAIL start_ignored row%0d: got s=%h u=%h idx=%0d, expected s=%h u=%h idx=%0d",
                     r, got_s[r], got_u[r], gidx[r], exp_s[r], exp_u[r], r);
         end
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL start_ignored control: got %b, expected 0000011000", ctl);
      end
   endtask

   task automatic test_back_to_back;
      fill_rand(3);
      run_job(3, 0, 0, 0, 0, 1, 6);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r]) begin
            n_fail++;
            $display("FAIL b2b_job1 row%0d: got s=%h u=%h, expected s=%h u=%h",
                     r, got_s[r], got_u[r], exp_s[r], exp_u[r]);
         end
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL b2b_job1 control: got %b, expected 0000011000", ctl);
      end
      fill_rand(6);
      run_job(6, 2, 0, 0, 1, 0, 0);
      for (int r = 0; r < N; r++) begin
         n_cmp++;
         if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r]) begin
            n_fail++;
            $display("FAIL b2b_job2 row%0d: got s=%h u=%h, expected s=%h u=%h",
                     r, got_s[r], got_u[r], exp_s[r], exp_u[r]);
         end
      end
      n_cmp++;
      if (ctl !== 10'b0000011000) begin
         n_fail++;
         $display("FAIL b2b_job2 control: got %b, expected 0000011000", ctl);
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 5; t++) begin
         int k;
         bit rt;
         k  = $urandom_range(1, 12);
         rt = 1'($urandom_range(0, 1));
         fill_rand(k);
         run_job(k, 2, rt, 0, 0, 0, 0);
         for (int r = 0; r < N; r++) begin
            n_cmp++;
            if (got_s[r] !== exp_s[r] || got_u[r] !== exp_u[r] || gidx[r] !== 2'(r)) begin
               n_fail++;
               $display("FAIL random%0d k=%0d row%0d: got s=%h u=%h idx=%0d, expected s=%h u=%h idx=%0d",
                        t, k, r, got_s[r], got_u[r], gidx[r], exp_s[r], exp_u[r], r);
            end
         end
         n_cmp++;
         if (ctl !== 10'b0000011000) begin
            n_fail++;
            $display("FAIL random%0d control: got %b, expected 0000011000", t, ctl);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity(0, 0, "identity");
      test_identity(1, 1, "stall");
      test_zero_k();
      test_signed_wrap();
      test_reset_mid_load();
      test_start_ignored();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
